// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, instruction fetch and IF/ID pipeline register
//
// Ports:
//   Clock            rising-edge clock
//   Reset            synchronous active-high reset
//   Stall            hold PC and IF/ID
//   BranchTaken      redirect request from EX; flushes IF/ID
//   BranchTarget     redirect byte address (taken modulo MEM_BYTES)
//   PCAddress        byte address to instruction memory (the PC register)
//   Instruction      combinational read data for PCAddress
//   IFID_Instruction registered instruction for decode
//   IFID_PCPlus2     registered fetch PC + 2, not wrapped
//   IFID_Valid       IF/ID holds a live instruction
//   Halted           unit is in HALT (or FAULT) state
//   FetchCount       instructions issued into IF/ID, wraps silently
//   MisalignFault    only with FETCH_MISALIGN_CHECK_EN: odd branch target seen
//
// Build option: define FETCH_MISALIGN_CHECK_EN to trap odd branch targets
// into a FAULT state that only Reset can leave.

module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          MEM_BYTES  = 128,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic [15:0] PCAddress,
    input  logic [15:0] Instruction,
    output logic [15:0] IFID_Instruction,
    output logic [15:0] IFID_PCPlus2,
    output logic        IFID_Valid,
    output logic        Halted,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        MisalignFault,
`endif
    output logic [15:0] FetchCount
);

    // MEM_BYTES is a power of two, so modulo reduces to a mask.
    localparam logic [15:0] ADDR_MASK = 16'(MEM_BYTES - 1);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_HALT = 2'd1, S_FAULT = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;
`endif

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] ifid_instr, ifid_instr_n;
    logic [15:0] ifid_pc2, ifid_pc2_n;
    logic        ifid_valid, ifid_valid_n;
    logic [15:0] fetch_count, fetch_count_n;
    logic [15:0] pc_plus2;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fault, fault_n;
`endif

    assign pc_plus2 = pc + 16'd2;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ifid_instr  <= 16'h0000;
            ifid_pc2    <= 16'h0000;
            ifid_valid  <= 1'b0;
            fetch_count <= 16'h0000;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            ifid_instr  <= ifid_instr_n;
            ifid_pc2    <= ifid_pc2_n;
            ifid_valid  <= ifid_valid_n;
            fetch_count <= fetch_count_n;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault       <= fault_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        ifid_instr_n  = ifid_instr;
        ifid_pc2_n    = ifid_pc2;
        ifid_valid_n  = ifid_valid;
        fetch_count_n = fetch_count;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_n       = fault;
`endif
        if (BranchTaken) begin
            // The branch is older than whatever sits in IF/ID, so it flushes
            // even when the hazard unit asks for a stall on the same edge.
            ifid_valid_n = 1'b0;
            ifid_instr_n = 16'h0000;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (state == S_FAULT) begin
                // FAULT is sticky; only Reset releases it.
            end else if (BranchTarget[0]) begin
                state_n = S_FAULT;
                fault_n = 1'b1;
            end else begin
                pc_n    = BranchTarget & ADDR_MASK;
                state_n = S_FETCH;
            end
`else
            pc_n    = BranchTarget & ADDR_MASK;
            state_n = S_FETCH;
`endif
        end else if (!Stall) begin
            case (state)
                S_FETCH: begin
                    ifid_instr_n  = Instruction;
                    ifid_pc2_n    = pc_plus2;
                    ifid_valid_n  = 1'b1;
                    fetch_count_n = fetch_count + 16'd1;
                    // The HALT word is issued, but PC parks on its address.
                    if (Instruction == HALT_INSTR) begin
                        state_n = S_HALT;
                    end else begin
                        pc_n = pc_plus2 & ADDR_MASK;
                    end
                end
                default: begin
                    // HALT / FAULT: feed bubbles to decode.
                    ifid_valid_n = 1'b0;
                end
            endcase
        end
    end

    assign PCAddress        = pc;
    assign IFID_Instruction = ifid_instr;
    assign IFID_PCPlus2     = ifid_pc2;
    assign IFID_Valid       = ifid_valid;
    assign FetchCount       = fetch_count;
    assign Halted           = (state != S_FETCH);
`ifdef FETCH_MISALIGN_CHECK_EN
    assign MisalignFault    = fault;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit

module tb_instruction_fetch_unit;

    localparam int MEMB = 128;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] PCAddress;
    logic [15:0] Instruction;
    logic [15:0] IFID_Instruction;
    logic [15:0] IFID_PCPlus2;
    logic        IFID_Valid;
    logic        Halted;
    logic [15:0] FetchCount;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        MisalignFault;
`endif

    logic [15:0] mem [0:MEMB/2-1];

    always #5 Clock = ~Clock;

    assign Instruction = mem[PCAddress[6:1]];

    instruction_fetch_unit dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .PCAddress        (PCAddress),
        .Instruction      (Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus2     (IFID_PCPlus2),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted),
`ifdef FETCH_MISALIGN_CHECK_EN
        .MisalignFault    (MisalignFault),
`endif
        .FetchCount       (FetchCount)
    );

    int errors = 0;
    int checks = 0;
    int cur_step = 0;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: actual=%h required=%h", name, cur_step, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] e_pc;
        logic [15:0] e_ins;
        logic [15:0] e_pc2;
        logic        e_v;
        logic        e_h;
        logic        ck_ins;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [0:21];

    // ---------------- reference model ----------------
    logic [15:0] m_pc, m_ins, m_pc2, m_cnt;
    logic        m_valid, m_halt, m_known, m_fault;

    task automatic model_step(input logic rst, input logic stall, input logic br, input logic [15:0] tgt);
        logic [15:0] w;
        if (rst) begin
            m_pc = 16'h0000; m_ins = 16'h0000; m_pc2 = 16'h0000; m_cnt = 16'h0000;
            m_valid = 1'b0; m_halt = 1'b0; m_known = 1'b1; m_fault = 1'b0;
        end else if (br) begin
            m_valid = 1'b0; m_ins = 16'h0000; m_known = 1'b1;
            if (!m_fault) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (tgt[0]) begin
                    m_fault = 1'b1;
                    m_halt  = 1'b1;
                end else begin
                    m_pc   = 16'(int'(tgt) % MEMB);
                    m_halt = 1'b0;
                end
`else
                m_pc   = 16'(int'(tgt) % MEMB);
                m_halt = 1'b0;
`endif
            end
        end else if (stall) begin
            // everything holds
        end else if (m_halt) begin
            m_valid = 1'b0;
            m_known = 1'b0;
        end else begin
            w = mem[(int'(m_pc) % MEMB) / 2];
            m_ins = w; m_known = 1'b1;
            m_pc2 = m_pc + 16'd2;
            m_valid = 1'b1;
            m_cnt = m_cnt + 16'd1;
            if (w == 16'hFFFF) m_halt = 1'b1;
            else m_pc = 16'((int'(m_pc) + 2) % MEMB);
        end
    endtask

    task automatic check_model();
        chk16("pc", PCAddress, m_pc);
        chk16("valid", {15'd0, IFID_Valid}, {15'd0, m_valid});
        chk16("halted", {15'd0, Halted}, {15'd0, m_halt});
        chk16("count", FetchCount, m_cnt);
        if (m_known) chk16("instr", IFID_Instruction, m_ins);
        if (m_valid) chk16("pcplus2", IFID_PCPlus2, m_pc2);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk16("fault", {15'd0, MisalignFault}, {15'd0, m_fault});
`endif
    endtask

    task automatic step_model(input logic rst, input logic stall, input logic br, input logic [15:0] tgt);
        Reset = rst; Stall = stall; BranchTaken = br; BranchTarget = tgt;
        model_step(rst, stall, br, tgt);
        @(posedge Clock);
        #1;
        cur_step++;
        check_model();
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;

        for (int i = 0; i < MEMB / 2; i++) mem[i] = 16'h0A00 + 16'(i);
        mem[0]  = 16'h1111;
        mem[1]  = 16'h2222;
        mem[2]  = 16'h3333;
        mem[3]  = 16'h4444;
        mem[4]  = 16'hFFFF;   // address 0x08
        mem[8]  = 16'h6666;   // address 0x10
        mem[16] = 16'h5555;   // address 0x20
        mem[63] = 16'h7777;   // address 0x7E

        //        rst  stl  br   tgt       pc        ins       pc2       v    h   ckins cnt
        vt[0]  = '{1'b1,1'b0,1'b0,16'h0000, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd0};
        vt[1]  = '{1'b0,1'b0,1'b0,16'h0000, 16'h0002,16'h1111,16'h0002,1'b1,1'b0,1'b1,16'd1};
        vt[2]  = '{1'b0,1'b0,1'b0,16'h0000, 16'h0004,16'h2222,16'h0004,1'b1,1'b0,1'b1,16'd2};
        vt[3]  = '{1'b0,1'b1,1'b0,16'h0000, 16'h0004,16'h2222,16'h0004,1'b1,1'b0,1'b1,16'd2};
        vt[4]  = '{1'b0,1'b1,1'b0,16'h0000, 16'h0004,16'h2222,16'h0004,1'b1,1'b0,1'b1,16'd2};
        vt[5]  = '{1'b0,1'b1,1'b0,16'h0000, 16'h0004,16'h2222,16'h0004,1'b1,1'b0,1'b1,16'd2};
        vt[6]  = '{1'b0,1'b0,1'b0,16'h0000, 16'h0006,16'h3333,16'h0006,1'b1,1'b0,1'b1,16'd3};
        vt[7]  = '{1'b0,1'b0,1'b0,16'h0000, 16'h0008,16'h4444,16'h0008,1'b1,1'b0,1'b1,16'd4};
        vt[8]  = '{1'b0,1'b1,1'b1,16'h0020, 16'h0020,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd4};
        vt[9]  = '{1'b0,1'b0,1'b0,16'h0000, 16'h0022,16'h5555,16'h0022,1'b1,1'b0,1'b1,16'd5};
        vt[10] = '{1'b0,1'b0,1'b1,16'h007E, 16'h007E,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd5};
        vt[11] = '{1'b0,1'b0,1'b0,16'h0000, 16'h0000,16'h7777,16'h0080,1'b1,1'b0,1'b1,16'd6};
        vt[12] = '{1'b0,1'b0,1'b1,16'h0008, 16'h0008,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd6};
        vt[13] = '{1'b0,1'b0,1'b0,16'h0000, 16'h0008,16'hFFFF,16'h000A,1'b1,1'b1,1'b1,16'd7};
        vt[14] = '{1'b0,1'b1,1'b0,16'h0000, 16'h0008,16'hFFFF,16'h000A,1'b1,1'b1,1'b1,16'd7};
        vt[15] = '{1'b0,1'b0,1'b0,16'h0000, 16'h0008,16'h0000,16'h0000,1'b0,1'b1,1'b0,16'd7};
        vt[16] = '{1'b0,1'b0,1'b0,16'h0000, 16'h0008,16'h0000,16'h0000,1'b0,1'b1,1'b0,16'd7};
        vt[17] = '{1'b0,1'b0,1'b1,16'h0010, 16'h0010,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd7};
        vt[18] = '{1'b0,1'b0,1'b0,16'h0000, 16'h0012,16'h6666,16'h0012,1'b1,1'b0,1'b1,16'd8};
        vt[19] = '{1'b0,1'b0,1'b1,16'h1234, 16'h0034,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd8};
        vt[20] = '{1'b0,1'b0,1'b0,16'h0000, 16'h0036,16'h0A1A,16'h0036,1'b1,1'b0,1'b1,16'd9};
        vt[21] = '{1'b1,1'b0,1'b1,16'h0040, 16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'd0};

        for (int s = 0; s < 22; s++) begin
            Reset = vt[s].rst; Stall = vt[s].stall;
            BranchTaken = vt[s].br; BranchTarget = vt[s].tgt;
            @(posedge Clock);
            #1;
            cur_step = s;
            chk16("t_pc", PCAddress, vt[s].e_pc);
            chk16("t_valid", {15'd0, IFID_Valid}, {15'd0, vt[s].e_v});
            chk16("t_halted", {15'd0, Halted}, {15'd0, vt[s].e_h});
            chk16("t_count", FetchCount, vt[s].e_cnt);
            if (vt[s].ck_ins) chk16("t_instr", IFID_Instruction, vt[s].e_ins);
            if (vt[s].e_v) chk16("t_pcplus2", IFID_PCPlus2, vt[s].e_pc2);
        end

        // Multi-cycle sequence: halt, long stall in HALT, release into bubbles.
        cur_step = 100;
        step_model(1'b1, 1'b0, 1'b0, 16'h0000);
        step_model(1'b0, 1'b0, 1'b1, 16'h0006);
        for (int i = 0; i < 6; i++) step_model(1'b0, (i >= 2 && i < 5), 1'b0, 16'h0000);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Odd target traps; FAULT survives further branches until Reset.
        step_model(1'b1, 1'b0, 1'b0, 16'h0000);
        step_model(1'b0, 1'b0, 1'b0, 16'h0000);
        step_model(1'b0, 1'b1, 1'b1, 16'h0013);
        chk16("fault_set", {15'd0, MisalignFault}, 16'd1);
        chk16("fault_pc", PCAddress, 16'h0002);
        for (int i = 0; i < 3; i++) step_model(1'b0, 1'b0, 1'b0, 16'h0000);
        step_model(1'b0, 1'b0, 1'b1, 16'h0020);
        chk16("fault_sticky", PCAddress, 16'h0002);
        step_model(1'b1, 1'b0, 1'b0, 16'h0000);
`endif

        // Randomised phase against the reference model.
        cur_step = 1000;
        for (int i = 0; i < MEMB / 2; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
        step_model(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int n = 0; n < 600; n++) begin
            step_model($urandom_range(0, 60) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7) == 0,
                       16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream and downstream wrapper around the instruction memory. Owns the program counter and drives the byte address to the memory.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with flush, a HALT instruction, and an issued-instruction counter.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MEM_BYTES, 128, instruction memory size in bytes. Even and a power of two. PC wraps modulo this value.
- HALT_INSTR, 16'hFFFF, encoding that stops sequential fetch.

Ports:
- Clock, input, 1, rising-edge clock.
- Reset, input, 1, synchronous active-high reset.
- Stall, input, 1, hazard unit request to hold PC and IF/ID.
- BranchTaken, input, 1, redirect request from EX stage.
- BranchTarget, input, 16, redirect byte address.
- PCAddress, output, 16, byte address to instruction memory. Equals the PC register.
- Instruction, input, 16, combinational read data from instruction memory for PCAddress.
- IFID_Instruction, output, 16, registered instruction to decode.
- IFID_PCPlus2, output, 16, registered (fetch PC + 2), unwrapped, for link/branch arithmetic.
- IFID_Valid, output, 1, IF/ID holds a live instruction.
- Halted, output, 1, unit is in HALT state.
- FetchCount, output, 16, number of instructions issued into IF/ID.

Behaviour:
- One clock, Clock. Reset is synchronous and active-high on Reset. All state updates on the rising edge.
- Reset values:
  - PC = RESET_PC
  - IFID_Instruction = 16'h0000
  - IFID_PCPlus2 = 16'h0000
  - IFID_Valid = 0
  - Halted = 0
  - FetchCount = 0
  - state = FETCH
- Reset asserted mid-operation overrides everything on that edge.
- Latency: the instruction at PC appears on IF/ID one clock after PCAddress presents it. No internal memory latency is assumed.
- Sequential next PC = (PC + 2) mod MEM_BYTES. With MEM_BYTES = 128, PC = 16'd126 is followed by 0. PC is always even in normal operation.
- Per-edge priority: Reset > BranchTaken > Stall > normal.
- State FETCH, normal (no Stall, no BranchTaken):
  - IF/ID <= {Instruction, PC + 2, valid = 1}
  - FetchCount += 1
  - PC <= next PC
  - If Instruction == HALT_INSTR, PC holds instead and state goes to HALT.
- State FETCH, Stall = 1: PC, IF/ID, FetchCount and state all hold.
- BranchTaken = 1 in any state:
  - PC <= BranchTarget mod MEM_BYTES
  - IFID_Valid <= 0 (flush). IFID_Instruction is set to 16'h0000.
  - FetchCount holds. State goes to FETCH; Halted clears.
  - Applies even if Stall = 1 on the same edge. The redirect wins and flushes, because the branch is older than the stalled instruction.
- State HALT:
  - PCAddress holds the HALT_INSTR address.
  - Each non-stalled edge: IFID_Valid <= 0 (bubble) and FetchCount holds.
  - Stall holds IF/ID unchanged. This preserves the HALT instruction if decode has not consumed it.
  - Only BranchTaken or Reset leaves HALT.
- Halted = (state == HALT), registered.
- FetchCount wraps from 16'hFFFF to 0 without flag.
- BranchTarget bits above log2(MEM_BYTES) are ignored. Bit 0 is passed through unchanged, except under the optional feature.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output MisalignFault (1 bit, reset 0) and state FAULT.
  - BranchTaken with BranchTarget[0] = 1 loads no PC, flushes IF/ID, sets MisalignFault = 1 and enters FAULT.
  - FAULT behaves as HALT, with Halted = 1. It is left only by Reset.
- When undefined: no port, no state; odd targets are loaded as-is.

Test Plan:
- Reset then 4 free-running cycles with memory words 0x1111, 0x2222, 0x3333, 0x4444 at addresses 0, 2, 4, 6 -> PCAddress goes 0, 2, 4, 6, 8. IF/ID shows 0x1111/PCPlus2 = 2, then 0x2222/4, and so on. FetchCount = 4. IFID_Valid = 0 only in the first cycle after reset.
- Stall high for 3 cycles while PC = 4 -> PCAddress stays 4, IF/ID and FetchCount frozen. On release, 0x3333 issues next.
- BranchTaken = 1, BranchTarget = 16'h0020 with Stall = 1 on the same edge -> next cycle PCAddress = 0x20, IFID_Valid = 0, FetchCount unchanged. The following cycle issues the word at 0x20.
- PC = 126, no stall -> IF/ID gets word at 126, PCAddress wraps to 0.
- Word 0xFFFF at address 8 -> issued with valid = 1, then Halted = 1, PCAddress stays 8, IFID_Valid = 0 thereafter. BranchTaken to 0x10 -> Halted = 0 and fetch resumes at 0x10.
- With FETCH_MISALIGN_CHECK_EN defined, BranchTarget = 16'h0013 -> MisalignFault = 1, Halted = 1, PC unchanged. Remains so until Reset.
